// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state enum and size constants for the FFT controller
package fft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_UNLOAD  = 3'd3,
        ST_DONE    = 3'd4
    } fft_ctrl_state_t;

    localparam int FFT_POINTS = 1024;
    localparam int FFT_HALF   = 512;
    localparam int FFT_STAGES = 10;
    localparam int FFT_IDX_W  = 10;

endpackage

// File: rtl/fft_bitrev.sv
// rtl/fft_bitrev.sv - parameterised combinational bit reverser
module fft_bitrev #(
    parameter int W = 10
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    // Mirror the index: bit i of the output is bit W-1-i of the input
    always_comb begin
        dout = '0;
        for (int i = 0; i < W; i++) begin
            dout[i] = din[W-1-i];
        end
    end

endmodule

// File: rtl/fft_controller.sv
// rtl/fft_controller.sv - load/compute/unload sequencer for the 1024-point FFT (optional FFT_CTRL_BITREV_EN)
module fft_controller
    import fft_pkg::*;
#(
    parameter int POINTS_LOG2 = FFT_IDX_W,
    parameter int STAGES      = POINTS_LOG2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic                   out_last,
    output logic                   externalLoad,
    output logic                   load,
    output logic                   scan,
    output logic [POINTS_LOG2-1:0] externalIndexA,
    output logic [4:0]             stageCount,
    output logic [POINTS_LOG2-2:0] cycleCount,
    output logic                   busy,
    output logic                   done
);

    // Last values of each counter; wrap is decided by compare, not overflow
    localparam logic [POINTS_LOG2-1:0] IDX_LAST   = '1;
    localparam logic [POINTS_LOG2-2:0] CYC_LAST   = '1;
    localparam logic [4:0]             STAGE_LAST = 5'(STAGES - 1);

    fft_ctrl_state_t        state;
    logic [POINTS_LOG2-1:0] idx_cnt;
    logic [4:0]             stage_cnt;
    logic [POINTS_LOG2-2:0] cycle_cnt;
    logic [POINTS_LOG2-1:0] unload_idx;

    // Sequencer: one counter serves both LOAD and UNLOAD since they never overlap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            idx_cnt   <= '0;
            stage_cnt <= '0;
            cycle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        idx_cnt   <= '0;
                        stage_cnt <= '0;
                        cycle_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        if (idx_cnt == IDX_LAST) begin
                            idx_cnt <= '0;
                            state   <= ST_COMPUTE;
                        end else begin
                            idx_cnt <= idx_cnt + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (cycle_cnt == CYC_LAST) begin
                        cycle_cnt <= '0;
                        if (stage_cnt == STAGE_LAST) begin
                            stage_cnt <= '0;
                            state     <= ST_UNLOAD;
                        end else begin
                            stage_cnt <= stage_cnt + 1'b1;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (out_valid && out_ready) begin
                        if (idx_cnt == IDX_LAST) begin
                            idx_cnt <= '0;
                            state   <= ST_DONE;
                        end else begin
                            idx_cnt <= idx_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FFT_CTRL_BITREV_EN
    // Readout walks the RAM in bit-reversed order so results leave in natural frequency order
    fft_bitrev #(.W(POINTS_LOG2)) u_bitrev (
        .din  (idx_cnt),
        .dout (unload_idx)
    );
`else
    // Readout in RAM order; the consumer reorders
    assign unload_idx = idx_cnt;
`endif

    // Strobes decode from registered state only; externalLoad also needs the beat
    assign in_ready       = (state == ST_LOAD);
    assign externalLoad   = (state == ST_LOAD) && in_valid;
    assign load           = (state == ST_COMPUTE);
    assign scan           = (state == ST_UNLOAD);
    assign out_valid      = (state == ST_UNLOAD);
    assign out_last       = (state == ST_UNLOAD) && (idx_cnt == IDX_LAST);
    assign busy           = (state != ST_IDLE);
    assign done           = (state == ST_DONE);
    assign stageCount     = stage_cnt;
    assign cycleCount     = cycle_cnt;
    assign externalIndexA = (state == ST_LOAD)   ? idx_cnt    :
                            (state == ST_UNLOAD) ? unload_idx : '0;

endmodule

// File: tb/tb_fft_controller.sv
// tb/tb_fft_controller.sv - self-checking bench for fft_controller
module tb_fft_controller;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic        out_last;
    logic        externalLoad;
    logic        load;
    logic        scan;
    logic [9:0]  externalIndexA;
    logic [4:0]  stageCount;
    logic [8:0]  cycleCount;
    logic        busy;
    logic        done;

    logic [31:0] in_data;
    logic [31:0] ram [0:1023];
    logic [31:0] exp_q [$];

    int errors;
    int checks;

    typedef struct {
        logic       start;
        logic       in_valid;
        logic       e_busy;
        logic       e_rdy;
        logic       e_ext;
        logic [9:0] e_idx;
    } vec_t;

    vec_t vecs [6];

    fft_controller dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_last       (out_last),
        .externalLoad   (externalLoad),
        .load           (load),
        .scan           (scan),
        .externalIndexA (externalIndexA),
        .stageCount     (stageCount),
        .cycleCount     (cycleCount),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sample RAM fed by the controller's external write strobe
    always @(posedge clk) begin
        if (externalLoad === 1'b1) ram[externalIndexA] <= in_data;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [9:0] rev10(input logic [9:0] v);
        logic [9:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r[9-i] = v[i];
        return r;
    endfunction

    function automatic logic [9:0] fidx(input int j);
`ifdef FFT_CTRL_BITREV_EN
        return rev10(10'(j));
`else
        return 10'(j);
`endif
    endfunction

    function automatic logic [31:0] pat(input int k);
        return 32'h0001_0000 + 32'(k) * 32'd7 + 32'd3;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_last"}, 32'(out_last), 0);
        check({tag, "_ext_load"}, 32'(externalLoad), 0);
        check({tag, "_load"}, 32'(load), 0);
        check({tag, "_scan"}, 32'(scan), 0);
        check({tag, "_index"}, 32'(externalIndexA), 0);
        check({tag, "_stage"}, 32'(stageCount), 0);
        check({tag, "_cycle"}, 32'(cycleCount), 0);
    endtask

    initial begin
        int n_first_done;
        int mm_strobe, mm_idx, mm_cnt, mm_excl;
        int k, load_cycles, mm_lidx, comp, beat, stall, mm_last;
        logic [31:0] e;
        bit found;

        errors = 0;
        checks = 0;
        in_data = '0;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd2};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'd3};

        // Reset state, with inputs that would disturb a broken decode
        rst = 1'b0;
        start = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        check_quiet("reset");

        // Table: IDLE/LOAD entry, ignored start, beat-gated index advance
        do_reset();
        for (int i = 0; i < 6; i++) begin
            start = vecs[i].start;
            in_valid = vecs[i].in_valid;
            tick();
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_ext_load", i), 32'(externalLoad), 32'(vecs[i].e_ext));
            check($sformatf("vec%0d_index", i), 32'(externalIndexA), 32'(vecs[i].e_idx));
            check($sformatf("vec%0d_load", i), 32'(load), 0);
            check($sformatf("vec%0d_scan", i), 32'(scan), 0);
        end

        // Full run with in_valid and out_ready held high, checked against phase timing
        do_reset();
        start = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        n_first_done = -1;
        mm_strobe = 0;
        mm_idx = 0;
        mm_cnt = 0;
        mm_excl = 0;
        for (int n = 1; n <= 7175; n++) begin
            logic e_ext, e_load, e_scan, e_done, e_last, e_busy;
            int e_idx, e_stage, e_cyc;
            e_ext  = (n >= 1) && (n <= 1024);
            e_load = (n >= 1025) && (n <= 6144);
            e_scan = (n >= 6145) && (n <= 7168);
            e_done = (n == 7169);
            e_last = (n == 7168);
            e_busy = (n >= 1) && (n <= 7169);
            e_idx   = e_ext ? n - 1 : (e_scan ? int'(fidx(n - 6145)) : 0);
            e_stage = e_load ? (n - 1025) / 512 : 0;
            e_cyc   = e_load ? (n - 1025) % 512 : 0;
            if ({busy, done, in_ready, out_valid, out_last, externalLoad, load, scan} !==
                {e_busy, e_done, e_ext, e_scan, e_last, e_ext, e_load, e_scan}) mm_strobe++;
            if (externalIndexA !== 10'(e_idx)) mm_idx++;
            if (stageCount !== 5'(e_stage) || cycleCount !== 9'(e_cyc)) mm_cnt++;
            if ((int'(load) + int'(scan) + int'(externalLoad)) > 1) mm_excl++;
            if (done === 1'b1 && n_first_done < 0) n_first_done = n;
            tick();
        end
        check("run_strobe_mismatch_cycles", mm_strobe, 0);
        check("run_index_mismatch_cycles", mm_idx, 0);
        check("run_counter_mismatch_cycles", mm_cnt, 0);
        check("run_exclusive_violations", mm_excl, 0);
        check("run_done_cycle", n_first_done, 7169);

        // Throttled LOAD: in_valid toggles starting low
        do_reset();
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        load_cycles = 0;
        mm_lidx = 0;
        for (int c = 0; c < 5000 && in_ready === 1'b1; c++) begin
            load_cycles++;
            if (externalIndexA !== 10'(k)) mm_lidx++;
            in_valid = c[0];
            in_data = pat(k);
            #1;
            if (externalLoad !== in_valid) mm_lidx++;
            if (in_valid) k++;
            tick();
        end
        check("toggle_load_cycles", load_cycles, 2048);
        check("toggle_load_beats", k, 1024);
        check("toggle_load_index_mismatch", mm_lidx, 0);

        // COMPUTE with stray start and in_valid, which must change nothing
        in_valid = 1'b1;
        comp = 0;
        for (int c = 0; c < 6000 && load === 1'b1; c++) begin
            comp++;
            start = (c == 100);
            tick();
        end
        start = 1'b0;
        check("compute_cycles", comp, 5120);
        check("unload_entered", 32'(scan), 1);

        // UNLOAD against the scoreboard, with a 5-cycle stall at beat 7
        for (int j = 0; j < 1024; j++) exp_q.push_back(pat(int'(fidx(j))));
        beat = 0;
        stall = 0;
        mm_last = 0;
        for (int c = 0; c < 3000 && scan === 1'b1; c++) begin
            if (out_last !== (beat == 1023)) mm_last++;
            if (out_valid !== 1'b1) mm_last++;
            if (beat == 7 && stall < 5) begin
                out_ready = 1'b0;
                check($sformatf("stall%0d_index", stall), 32'(externalIndexA), 32'(fidx(7)));
                check($sformatf("stall%0d_out_valid", stall), 32'(out_valid), 1);
                check($sformatf("stall%0d_out_last", stall), 32'(out_last), 0);
                stall++;
            end else begin
                out_ready = 1'b1;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = 32'hFFFF_FFFF;
                check($sformatf("unload_data_beat%0d", beat), ram[externalIndexA], e);
                beat++;
            end
            tick();
        end
        check("unload_beats", beat, 1024);
        check("scoreboard_left", exp_q.size(), 0);
        check("unload_last_valid_mismatch", mm_last, 0);
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 1);
        tick();
        check("after_done_pulse", 32'(done), 0);
        check("after_done_busy", 32'(busy), 0);

        // Asynchronous reset in the middle of COMPUTE
        do_reset();
        start = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            if (load === 1'b1 && stageCount == 5'd4 && cycleCount == 9'd100) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("reach_stage4_cycle100", 32'(found), 1);
        rst = 1'b0;
        #1;
        check_quiet("async_reset");
        tick();
        check_quiet("reset_next_cycle");
        rst = 1'b1;
        tick();
        check("idle_after_release", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
